// File: rtl/rps_round_ctrl_if.sv
// rps_round_ctrl_if: sign strobes in, four segment buses and status out.
//
// Handshake: A_VALID/B_VALID are single-cycle qualifiers for A_SIGN/B_SIGN,
// sampled on the rising clock edge. There is no ready signal. A strobe is
// consumed only in WAIT, and only while that player has not yet played.
// Strobes arriving at any other time are dropped and are never queued.
interface rps_round_ctrl_if;
    logic        A_VALID;
    logic [0:1]  A_SIGN;
    logic        B_VALID;
    logic [0:1]  B_SIGN;
    logic [0:12] LDISP;
    logic [0:12] RDISP;
    logic [0:12] SC_LDISP;
    logic [0:12] SC_RDISP;
    logic        ROUND_DONE;
    logic        GAME_OVER;
    logic [1:0]  STATE_DBG;

    modport master (
        output A_VALID, A_SIGN, B_VALID, B_SIGN,
        input  LDISP, RDISP, SC_LDISP, SC_RDISP, ROUND_DONE, GAME_OVER, STATE_DBG
    );

    modport slave (
        input  A_VALID, A_SIGN, B_VALID, B_SIGN,
        output LDISP, RDISP, SC_LDISP, SC_RDISP, ROUND_DONE, GAME_OVER, STATE_DBG
    );
endinterface

// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl: muk-jji-ppa round sequencer. It collects both signs, scores
// the round, shows the hands for HOLD_CYC cycles, and ends the match on
// WIN_SCORE or MAX_ROUNDS.
// Optional macro TIMEOUT_EN: when a sign is missing, it is forced to INVALID
// after TIMEOUT_CYC cycles.
// STATE_DBG encoding: 0 WAIT, 1 EVAL, 2 SHOW, 3 END.
module rps_round_ctrl #(
    parameter int WIN_SCORE   = 3,
    parameter int MAX_ROUNDS  = 9,
    parameter int HOLD_CYC    = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input logic             CLK,
    input logic             RST,
    rps_round_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_EVAL = 2'd1,
        ST_SHOW = 2'd2,
        ST_END  = 2'd3
    } state_e;

    localparam logic [1:0] SIGN_ROCK  = 2'b00;
    localparam logic [1:0] SIGN_SCIS  = 2'b01;
    localparam logic [1:0] SIGN_PAPER = 2'b10;
    localparam logic [1:0] SIGN_INV   = 2'b11;

    localparam logic [0:12] PAT_BLANK  = 13'b0000000000000;
    localparam logic [0:12] PAT_MID    = 13'b0000001000000;
    localparam logic [0:12] PAT_A_WINR = 13'b0000000100100;
    localparam logic [0:12] PAT_B_WINL = 13'b0000000001001;

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    // Parameter sanity is enforced at elaboration time.
    if (WIN_SCORE < 1 || WIN_SCORE > 9 || MAX_ROUNDS < 1 || MAX_ROUNDS > 15 ||
        HOLD_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("rps_round_ctrl: parameter out of legal range");
    end

    function automatic logic [0:12] hand_pat(input logic [1:0] s);
        case (s)
            SIGN_ROCK:  return 13'b0011101000111;
            SIGN_SCIS:  return 13'b0011101101010;
            SIGN_PAPER: return 13'b0111111010000;
            default:    return 13'b0000000101101;
        endcase
    endfunction

    function automatic logic [0:12] digit_pat(input logic [3:0] d);
        case (d)
            4'd0:    return 13'b1111110000000;
            4'd1:    return 13'b0110000000000;
            4'd2:    return 13'b1101101000000;
            4'd3:    return 13'b1111001000000;
            4'd4:    return 13'b0110011000000;
            4'd5:    return 13'b1011011000000;
            4'd6:    return 13'b1011111000000;
            4'd7:    return 13'b1110010000000;
            4'd8:    return 13'b1111111000000;
            default: return 13'b1111011000000;
        endcase
    endfunction

    // x beats y: any valid sign beats INVALID, otherwise the usual cycle.
    function automatic logic beats(input logic [1:0] x, input logic [1:0] y);
        if (x == SIGN_INV) return 1'b0;
        if (y == SIGN_INV) return 1'b1;
        return (x == SIGN_ROCK  && y == SIGN_SCIS)  ||
               (x == SIGN_SCIS  && y == SIGN_PAPER) ||
               (x == SIGN_PAPER && y == SIGN_ROCK);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= 4'd9) ? 4'd9 : v + 4'd1;
    endfunction

    state_e state_q, state_d;
    logic              a_got_q, a_got_d, b_got_q, b_got_d;
    logic [1:0]        a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [3:0]        a_score_q, a_score_d, b_score_q, b_score_d;
    logic [3:0]        round_q, round_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [0:12]       ldisp_q, ldisp_d, rdisp_q, rdisp_d;
    logic              round_done_q, round_done_d;
    logic              match_over;
    logic              to_fire;

    assign match_over = (a_score_q == 4'(WIN_SCORE)) || (b_score_q == 4'(WIN_SCORE)) ||
                        (round_q == 4'(MAX_ROUNDS));

`ifdef TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_q, to_d;

    // The timeout expires only if the missing player does not strobe in that same cycle.
    assign to_fire = (state_q == ST_WAIT) && (a_got_q ^ b_got_q) && (to_q == TO_LAST) &&
                     !(a_got_q ? bus.B_VALID : bus.A_VALID);

    // The wait counter runs only while exactly one sign is held in WAIT.
    always_comb begin
        to_d = '0;
        if (state_q == ST_WAIT && (a_got_q ^ b_got_q) && !to_fire) to_d = to_q + 1'b1;
    end

    // Wait counter register.
    always_ff @(posedge CLK) begin
        if (RST) to_q <= '0;
        else     to_q <= to_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if ((a_got_q && b_got_q) || to_fire) state_d = ST_EVAL;
            ST_EVAL: state_d = ST_SHOW;
            ST_SHOW: if (hold_q == HOLD_LAST) state_d = match_over ? ST_END : ST_WAIT;
            default: state_d = ST_END;
        endcase
    end

    // Datapath and output next values: latch signs, score the round, and drive the displays.
    always_comb begin
        a_got_d      = a_got_q;
        b_got_d      = b_got_q;
        a_sign_d     = a_sign_q;
        b_sign_d     = b_sign_q;
        a_score_d    = a_score_q;
        b_score_d    = b_score_q;
        round_d      = round_q;
        hold_d       = hold_q;
        ldisp_d      = ldisp_q;
        rdisp_d      = rdisp_q;
        round_done_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (bus.A_VALID && !a_got_q) begin
                    a_got_d  = 1'b1;
                    a_sign_d = bus.A_SIGN;
                end
                if (bus.B_VALID && !b_got_q) begin
                    b_got_d  = 1'b1;
                    b_sign_d = bus.B_SIGN;
                end
                if (to_fire) begin
                    if (!a_got_q) begin
                        a_got_d  = 1'b1;
                        a_sign_d = SIGN_INV;
                    end else begin
                        b_got_d  = 1'b1;
                        b_sign_d = SIGN_INV;
                    end
                end
            end
            ST_EVAL: begin
                ldisp_d      = hand_pat(a_sign_q);
                rdisp_d      = hand_pat(b_sign_q);
                if (beats(a_sign_q, b_sign_q)) a_score_d = sat_inc(a_score_q);
                if (beats(b_sign_q, a_sign_q)) b_score_d = sat_inc(b_score_q);
                round_d      = round_q + 4'd1;
                hold_d       = '0;
                round_done_d = 1'b1;
            end
            ST_SHOW: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    if (match_over) begin
                        if (a_score_q > b_score_q) begin
                            ldisp_d = PAT_MID;
                            rdisp_d = PAT_A_WINR;
                        end else if (b_score_q > a_score_q) begin
                            ldisp_d = PAT_B_WINL;
                            rdisp_d = PAT_MID;
                        end else begin
                            ldisp_d = PAT_MID;
                            rdisp_d = PAT_MID;
                        end
                    end else begin
                        a_got_d = 1'b0;
                        b_got_d = 1'b0;
                        ldisp_d = PAT_BLANK;
                        rdisp_d = PAT_BLANK;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            a_got_q      <= 1'b0;
            b_got_q      <= 1'b0;
            a_sign_q     <= SIGN_ROCK;
            b_sign_q     <= SIGN_ROCK;
            a_score_q    <= 4'd0;
            b_score_q    <= 4'd0;
            round_q      <= 4'd0;
            hold_q       <= '0;
            ldisp_q      <= PAT_BLANK;
            rdisp_q      <= PAT_BLANK;
            round_done_q <= 1'b0;
        end else begin
            a_got_q      <= a_got_d;
            b_got_q      <= b_got_d;
            a_sign_q     <= a_sign_d;
            b_sign_q     <= b_sign_d;
            a_score_q    <= a_score_d;
            b_score_q    <= b_score_d;
            round_q      <= round_d;
            hold_q       <= hold_d;
            ldisp_q      <= ldisp_d;
            rdisp_q      <= rdisp_d;
            round_done_q <= round_done_d;
        end
    end

    assign bus.LDISP      = ldisp_q;
    assign bus.RDISP      = rdisp_q;
    assign bus.SC_LDISP   = digit_pat(a_score_q);
    assign bus.SC_RDISP   = digit_pat(b_score_q);
    assign bus.ROUND_DONE = round_done_q;
    assign bus.GAME_OVER  = (state_q == ST_END);
    assign bus.STATE_DBG  = state_q;
endmodule

// File: tb/tb_rps_round_ctrl.sv
// tb_rps_round_ctrl: scoreboard bench for rps_round_ctrl (WIN_SCORE 3, MAX_ROUNDS 4).
module tb_rps_round_ctrl;
    localparam int WIN  = 3;
    localparam int MAXR = 4;
    localparam int HOLD = 4;
    localparam int TOC  = 16;

    localparam logic [1:0] S_R = 2'b00, S_S = 2'b01, S_P = 2'b10, S_I = 2'b11;
    localparam logic [12:0] P_BLANK = 13'b0000000000000;
    localparam logic [12:0] P_MID   = 13'b0000001000000;
    localparam logic [12:0] P_AWR   = 13'b0000000100100;
    localparam logic [12:0] P_BWL   = 13'b0000000001001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rps_round_ctrl_if bus();

    rps_round_ctrl #(
        .WIN_SCORE(WIN), .MAX_ROUNDS(MAXR), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TOC)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [51:0] exp_q[$];
    int ma, mb, mr;

    function automatic logic [12:0] hand_pat(input logic [1:0] s);
        case (s)
            S_R:     return 13'b0011101000111;
            S_S:     return 13'b0011101101010;
            S_P:     return 13'b0111111010000;
            default: return 13'b0000000101101;
        endcase
    endfunction

    function automatic logic [12:0] digit_pat(input int d);
        logic [12:0] t[10];
        t = '{13'b1111110000000, 13'b0110000000000, 13'b1101101000000, 13'b1111001000000,
              13'b0110011000000, 13'b1011011000000, 13'b1011111000000, 13'b1110010000000,
              13'b1111111000000, 13'b1111011000000};
        return t[d];
    endfunction

    // 0 nobody, 1 A, 2 B
    function automatic int winner(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return 0;
        if (a == S_I) return 2;
        if (b == S_I) return 1;
        if ((a == S_R && b == S_S) || (a == S_S && b == S_P) || (a == S_P && b == S_R)) return 1;
        return 2;
    endfunction

    function automatic logic [25:0] end_pats(input int a, input int b);
        if (a > b) return {P_MID, P_AWR};
        if (b > a) return {P_BWL, P_MID};
        return {P_MID, P_MID};
    endfunction

    function automatic bit model_over();
        return (ma == WIN) || (mb == WIN) || (mr == MAXR);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ma = 0; mb = 0; mr = 0;
        exp_q.delete();
    endtask

    // ga/gb: cycle of the A/B strobe (gb < 0: B never plays), ra: optional A re-pulse.
    task automatic run_round(input logic [1:0] as, input logic [1:0] bs, input int ga,
                             input int gb, input int ra, input logic [1:0] rsign,
                             input bit wait_hold, output logic [51:0] obs,
                             output int lat, output logic rd_after);
        logic [1:0] eb;
        int w, last;
        eb = (gb < 0) ? S_I : bs;
        w = winner(as, eb);
        if (w == 1) ma++;
        if (w == 2) mb++;
        mr++;
        exp_q.push_back({hand_pat(as), hand_pat(eb), digit_pat(ma), digit_pat(mb)});
        last = ga;
        if (gb > last) last = gb;
        if (ra > last) last = ra;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            bus.A_VALID = (c == ga) || (c == ra);
            bus.A_SIGN  = (c == ra) ? rsign : as;
            bus.B_VALID = (c == gb);
            bus.B_SIGN  = bs;
        end
        @(negedge clk);
        bus.A_VALID = 1'b0;
        bus.B_VALID = 1'b0;
        lat = 0;
        while (lat < 64) begin
            @(negedge clk);
            lat++;
            if (bus.ROUND_DONE) break;
        end
        obs = {bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP};
        rd_after = 1'b0;
        if (wait_hold) begin
            @(negedge clk);
            rd_after = bus.ROUND_DONE;
            repeat (HOLD - 1) @(negedge clk);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        do_reset();
        n_vec++; if (bus.STATE_DBG !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", bus.STATE_DBG); end
        n_vec++; if (bus.LDISP !== P_BLANK) begin n_err++; $display("FAIL reset_ldisp: got %b want %b", bus.LDISP, P_BLANK); end
        n_vec++; if (bus.RDISP !== P_BLANK) begin n_err++; $display("FAIL reset_rdisp: got %b want %b", bus.RDISP, P_BLANK); end
        n_vec++; if (bus.SC_LDISP !== digit_pat(0)) begin n_err++; $display("FAIL reset_scl: got %b want %b", bus.SC_LDISP, digit_pat(0)); end
        n_vec++; if (bus.SC_RDISP !== digit_pat(0)) begin n_err++; $display("FAIL reset_scr: got %b want %b", bus.SC_RDISP, digit_pat(0)); end
        n_vec++; if (bus.ROUND_DONE !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %b want 0", bus.ROUND_DONE); end
        n_vec++; if (bus.GAME_OVER !== 1'b0) begin n_err++; $display("FAIL reset_go: got %b want 0", bus.GAME_OVER); end
    endtask

    task automatic test_same_cycle();
        logic [51:0] obs, e;
        int lat;
        logic rda;
        run_round(S_R, S_S, 0, 0, -1, S_R, 1'b1, obs, lat, rda);
        e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL same_cycle_disp: got %h want %h", obs, e); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL same_cycle_latency: got %0d want 2", lat); end
        n_vec++; if (rda !== 1'b0) begin n_err++; $display("FAIL round_done_width: got %b want 0", rda); end
        n_vec++; if (bus.LDISP !== P_BLANK || bus.STATE_DBG !== 2'd0) begin
            n_err++; $display("FAIL back_to_wait: got %b/%0d want %b/0", bus.LDISP, bus.STATE_DBG, P_BLANK);
        end
    endtask

    task automatic test_repulse();
        logic [51:0] obs, e;
        int lat;
        logic rda;
        run_round(S_P, S_P, 3, 7, 5, S_R, 1'b1, obs, lat, rda);
        e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL repulse_disp: got %h want %h", obs, e); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL repulse_latency: got %0d want 2", lat); end
    endtask

    task automatic test_win_score();
        logic [51:0] obs, e;
        int lat, rd_seen;
        logic rda;
        logic [1:0] ta[3], tb[3];
        ta = '{S_R, S_S, S_P};
        tb = '{S_S, S_P, S_R};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            run_round(ta[i], tb[i], $urandom_range(0, 3), $urandom_range(0, 3), -1, S_R, 1'b1, obs, lat, rda);
            e = exp_q.pop_front();
            n_vec++; if (obs !== e) begin n_err++; $display("FAIL win_round%0d: got %h want %h", i, obs, e); end
            n_vec++; if (bus.GAME_OVER !== (i == 2)) begin n_err++; $display("FAIL win_go%0d: got %b want %b", i, bus.GAME_OVER, (i == 2)); end
        end
        n_vec++; if ({bus.LDISP, bus.RDISP} !== {P_MID, P_AWR}) begin
            n_err++; $display("FAIL win_end_pat: got %b %b want %b %b", bus.LDISP, bus.RDISP, P_MID, P_AWR);
        end
        n_vec++; if (bus.SC_LDISP !== 13'b1111001000000) begin n_err++; $display("FAIL win_end_scl: got %b want 1111001000000", bus.SC_LDISP); end
        rd_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            bus.A_VALID = 1'b1; bus.A_SIGN = S_P;
            bus.B_VALID = 1'b1; bus.B_SIGN = S_R;
            if (bus.ROUND_DONE) rd_seen++;
        end
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.ROUND_DONE) rd_seen++;
        end
        n_vec++; if (rd_seen != 0) begin n_err++; $display("FAIL end_ignores_rd: got %0d want 0", rd_seen); end
        n_vec++; if ({bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP, bus.STATE_DBG} !==
                     {P_MID, P_AWR, digit_pat(3), digit_pat(0), 2'd3}) begin
            n_err++; $display("FAIL end_hold: got %b %b %b %b %0d", bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP, bus.STATE_DBG);
        end
    endtask

    task automatic test_round_limit();
        logic [51:0] obs, e;
        int lat;
        logic rda;
        logic [1:0] ta[4], tb[4];
        ta = '{S_R, S_R, S_S, S_I};
        tb = '{S_S, S_P, S_S, S_I};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_round(ta[i], tb[i], $urandom_range(0, 3), $urandom_range(0, 3), -1, S_R, 1'b1, obs, lat, rda);
            e = exp_q.pop_front();
            n_vec++; if (obs !== e) begin n_err++; $display("FAIL limit_round%0d: got %h want %h", i, obs, e); end
        end
        n_vec++; if ({bus.GAME_OVER, bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP} !==
                     {1'b1, P_MID, P_MID, digit_pat(1), digit_pat(1)}) begin
            n_err++; $display("FAIL limit_end: got %b %b %b %b %b", bus.GAME_OVER, bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP);
        end
    endtask

    task automatic test_invalid_reset();
        logic [51:0] obs, e;
        int lat;
        logic rda;
        do_reset();
        run_round(S_I, S_R, 1, 0, -1, S_R, 1'b0, obs, lat, rda);
        e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL invalid_disp: got %h want %h", obs, e); end
        n_vec++; if (lat != 2) begin n_err++; $display("FAIL invalid_latency: got %0d want 2", lat); end
        rst = 1'b1;
        bus.A_VALID = 1'b1; bus.A_SIGN = S_R;
        bus.B_VALID = 1'b1; bus.B_SIGN = S_P;
        @(negedge clk);
        n_vec++; if ({bus.STATE_DBG, bus.LDISP, bus.RDISP, bus.SC_LDISP, bus.SC_RDISP, bus.ROUND_DONE, bus.GAME_OVER} !==
                     {2'd0, P_BLANK, P_BLANK, digit_pat(0), digit_pat(0), 1'b0, 1'b0}) begin
            n_err++; $display("FAIL show_reset: got %0d %b %b %b %b %b %b", bus.STATE_DBG, bus.LDISP, bus.RDISP,
                              bus.SC_LDISP, bus.SC_RDISP, bus.ROUND_DONE, bus.GAME_OVER);
        end
        rst = 1'b0;
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        ma = 0; mb = 0; mr = 0;
    endtask

    task automatic test_random();
        logic [51:0] obs, e;
        int lat, guard;
        logic rda;
        do_reset();
        guard = 0;
        while (!model_over() && guard < 10) begin
            run_round(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 4),
                      $urandom_range(0, 4), -1, S_R, 1'b1, obs, lat, rda);
            e = exp_q.pop_front();
            n_vec++; if (obs !== e || lat != 2) begin n_err++; $display("FAIL random_round%0d: got %h lat %0d want %h lat 2", guard, obs, lat, e); end
            guard++;
        end
        n_vec++; if ({bus.GAME_OVER, bus.LDISP, bus.RDISP} !== {1'b1, end_pats(ma, mb)}) begin
            n_err++; $display("FAIL random_end: got %b %b %b want 1 %b", bus.GAME_OVER, bus.LDISP, bus.RDISP, end_pats(ma, mb));
        end
    endtask

`ifdef TIMEOUT_EN
    task automatic test_timeout();
        logic [51:0] obs, e;
        int lat;
        logic rda;
        do_reset();
        run_round(S_S, S_R, 0, -1, -1, S_S, 1'b1, obs, lat, rda);
        e = exp_q.pop_front();
        n_vec++; if (obs !== e) begin n_err++; $display("FAIL timeout_disp: got %h want %h", obs, e); end
        n_vec++; if (lat >= 64) begin n_err++; $display("FAIL timeout_no_round: got %0d cycles want < 64", lat); end
    endtask
`endif

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        bus.A_VALID = 1'b0; bus.A_SIGN = S_R;
        bus.B_VALID = 1'b0; bus.B_SIGN = S_R;
        test_reset();
        test_same_cycle();
        test_repulse();
        test_win_score();
        test_round_limit();
        test_invalid_reset();
        test_random();
`ifdef TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
